// File: rtl/conv1_event_scatter.sv
// conv1 event FIFO producer: expands one spike into (co, window, tap) words.
// Define CONV1_SCATTER_CNT_EN to add a saturating accepted-spike counter port.
module conv1_event_scatter #(
  parameter int CONV1_CHANNEL_NUM_O = 128,
  parameter int CONV1_CHANNEL_NUM_I = 256,
  parameter int CH_O_W = 7,
  parameter int CH_I_W = 8,
  parameter int WORD_W = 23
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              spike_valid,
  output logic              spike_ready,
  input  logic [CH_I_W-1:0] spike_channel,
  input  logic [1:0]        spike_x,
  input  logic [1:0]        spike_y,
  input  logic              full,
  input  logic              almost_full,
  output logic              w_en,
  output logic [WORD_W-1:0] w_data,
  output logic              busy,
  output logic              event_done
`ifdef CONV1_SCATTER_CNT_EN
  ,
  output logic [15:0]       event_cnt
`endif
);

  if (CONV1_CHANNEL_NUM_I > (1 << CH_I_W) ||
      CONV1_CHANNEL_NUM_O > (1 << CH_O_W) ||
      CONV1_CHANNEL_NUM_O < 1 ||
      WORD_W != CH_I_W + CH_O_W + 8) begin : g_param_err
    $error("conv1_event_scatter: inconsistent parameters");
  end

  typedef enum logic {IDLE, SCAN} state_e;

  localparam logic [CH_O_W-1:0] CO_LAST =
    CH_O_W'(CONV1_CHANNEL_NUM_O - 1);

  state_e state_q, state_d;
  logic [CH_I_W-1:0] ch_q, ch_d;
  logic [1:0] sx_q, sx_d;
  logic [1:0] sy_q, sy_d;
  logic [CH_O_W-1:0] co_q, co_d;
  logic [1:0] win_q, win_d;
  logic done_q, done_d;
  logic init_q;

  logic [1:0] px, py;
  logic [2:0] tx, ty;
  logic tap_valid, scan, adv, last, accept;
  logic unused_af;

  assign unused_af = almost_full;

  always_comb begin
    scan = (state_q == SCAN);
    spike_ready = (state_q == IDLE) && init_q;
    busy = scan;
    event_done = done_q;
    accept = spike_valid && spike_ready;
    // win walks (py,px) = (1,1),(1,2),(2,1),(2,2)
    px = win_q[0] ? 2'd2 : 2'd1;
    py = win_q[1] ? 2'd2 : 2'd1;
    tx = {1'b0, sx_q} + 3'd1 - {1'b0, px};
    ty = {1'b0, sy_q} + 3'd1 - {1'b0, py};
    tap_valid = (tx == 3'd1 || tx == 3'd2) &&
                (ty == 3'd1 || ty == 3'd2);
    w_en = scan && tap_valid && !full;
    w_data = '0;
    if (w_en) begin
      w_data = {ch_q, tx[1:0], ty[1:0], co_q, px, py};
    end
    adv = scan && (!tap_valid || w_en);
    last = (co_q == CO_LAST) && (win_q == 2'd3);
  end

  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    sx_d = sx_q;
    sy_d = sy_q;
    co_d = co_q;
    win_d = win_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ch_d = spike_channel;
          sx_d = spike_x;
          sy_d = spike_y;
          co_d = '0;
          win_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (adv) begin
          if (last) begin
            state_d = IDLE;
            done_d = 1'b1;
          end else begin
            win_d = win_q + 2'd1;
            if (win_q == 2'd3) begin
              co_d = co_q + CH_O_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ch_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      co_q <= '0;
      win_q <= '0;
      done_q <= 1'b0;
      init_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      co_q <= co_d;
      win_q <= win_d;
      done_q <= done_d;
      init_q <= 1'b1;
    end
  end

`ifdef CONV1_SCATTER_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
    event_cnt = cnt_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_conv1_event_scatter.sv
// Scoreboard bench for conv1_event_scatter with NUM_O=4.
// Directed cases, a stall, a mid-scan reset, then random spikes under random full.
module tb_conv1_event_scatter;

  localparam int NUM_O = 4;

  typedef struct {
    bit          v;
    logic [22:0] w;
  } step_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic spike_valid = 1'b0;
  logic spike_ready;
  logic [7:0] spike_channel = '0;
  logic [1:0] spike_x = '0;
  logic [1:0] spike_y = '0;
  logic full = 1'b0;
  logic almost_full = 1'b0;
  logic w_en;
  logic [22:0] w_data;
  logic busy;
  logic event_done;
`ifdef CONV1_SCATTER_CNT_EN
  logic [15:0] event_cnt;
  int cnt_m = 0;
`endif

  int checks = 0;
  int errors = 0;
  step_t steps[$];
  bit done_due = 0;
  bit ready_ok = 0;
  bit full_rand = 0;

  conv1_event_scatter #(
    .CONV1_CHANNEL_NUM_O(NUM_O)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .spike_valid(spike_valid),
    .spike_ready(spike_ready),
    .spike_channel(spike_channel),
    .spike_x(spike_x),
    .spike_y(spike_y),
    .full(full),
    .almost_full(almost_full),
    .w_en(w_en),
    .w_data(w_data),
    .busy(busy),
    .event_done(event_done)
`ifdef CONV1_SCATTER_CNT_EN
    ,
    .event_cnt(event_cnt)
`endif
  );

  always #5 clk = ~clk;

  // spike_ready may rise only on the first clock after reset release
  always @(posedge clk or negedge rstn) begin
    if (!rstn) ready_ok <= 1'b0;
    else ready_ok <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // every cycle of the scan in order: co outer, window inner
  task automatic push_spike(input int ch, input int x, input int y);
    step_t s;
    int px, py, tx, ty;
    for (int co = 0; co < NUM_O; co++) begin
      for (int w = 0; w < 4; w++) begin
        px = (w % 2) + 1;
        py = (w / 2) + 1;
        tx = x + 1 - px;
        ty = y + 1 - py;
        s.v = (tx >= 1 && tx <= 2 && ty >= 1 && ty <= 2);
        s.w = s.v ? 23'((ch << 15) | (tx << 13) | (ty << 11) |
                        (co << 4) | (px << 2) | py) : 23'd0;
        steps.push_back(s);
      end
    end
  endtask

  always @(negedge clk) begin
    step_t st;
    if (!rstn) begin
      chk("rst_ready", {31'd0, spike_ready}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, event_done}, 0);
      chk("rst_wen", {31'd0, w_en}, 0);
      chk("rst_wdata", {9'd0, w_data}, 0);
      steps.delete();
      done_due = 0;
`ifdef CONV1_SCATTER_CNT_EN
      cnt_m = 0;
      chk("rst_cnt", {16'd0, event_cnt}, 0);
`endif
    end else begin
      chk("event_done", {31'd0, event_done}, {31'd0, done_due});
      done_due = 0;
`ifdef CONV1_SCATTER_CNT_EN
      chk("event_cnt", {16'd0, event_cnt}, cnt_m);
`endif
      if (steps.size() != 0) begin
        chk("scan_busy", {31'd0, busy}, 1);
        chk("scan_ready", {31'd0, spike_ready}, 0);
        st = steps[0];
        if (st.v && full) begin
          chk("stall_wen", {31'd0, w_en}, 0);
          chk("stall_wdata", {9'd0, w_data}, 0);
        end else begin
          if (st.v) begin
            chk("w_en", {31'd0, w_en}, 1);
            chk("w_data", {9'd0, w_data}, {9'd0, st.w});
          end else begin
            chk("skip_wen", {31'd0, w_en}, 0);
            chk("skip_wdata", {9'd0, w_data}, 0);
          end
          void'(steps.pop_front());
          if (steps.size() == 0) done_due = 1;
        end
      end else begin
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_wen", {31'd0, w_en}, 0);
        chk("idle_wdata", {9'd0, w_data}, 0);
        chk("idle_ready", {31'd0, spike_ready}, {31'd0, ready_ok});
        if (spike_valid && ready_ok) begin
          push_spike(int'(spike_channel), int'(spike_x), int'(spike_y));
`ifdef CONV1_SCATTER_CNT_EN
          if (cnt_m != 16'hFFFF) cnt_m++;
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (full_rand) full = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send(input int ch, input int x, input int y);
    int n;
    spike_channel = 8'(ch);
    spike_x = 2'(x);
    spike_y = 2'(y);
    spike_valid = 1'b1;
    n = 0;
    while (!spike_ready && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      errors++;
      $display("FAIL send_timeout: spike_ready stuck 0 at %0t", $time);
    end
    tick();
    spike_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((steps.size() != 0 || done_due) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      errors++;
      $display("FAIL idle_timeout: %0d steps left at %0t",
               steps.size(), $time);
    end
    tick();
  endtask

  initial begin
    repeat (3) tick();
    rstn = 1'b1;
    repeat (2) tick();

    send(5, 1, 1);
    send(0, 2, 2);
    send(11, 0, 3);
    send(200, 3, 0);
    wait_idle();

    send(7, 2, 2);
    repeat (4) tick();
    full = 1'b1;
    repeat (3) tick();
    full = 1'b0;
    wait_idle();

    send(9, 2, 2);
    repeat (6) tick();
    #3 rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    send(3, 2, 2);
    wait_idle();

    full_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 20)) tick();
    end
    wait_idle();
    full_rand = 1'b0;
    full = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
